// File: rtl/detect_collector.sv
// detect_collector
//   Receiving end of the classifier detection stream. Collects packed window
//   positions for one frame into a small register array, then replays the
//   list as an unpacked x/y stream once the frame terminator arrives.
//
//   Optional feature macro: DETECT_COLLECT_DEDUP_EN
//     When defined, a non-eot beat equal to the most recently stored entry of
//     the current frame is discarded (not stored, not counted, no overflow).
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   detect_pos_valid    input beat valid
//   detect_pos_ready    collector accepts beats (high only while collecting)
//   detect_pos_eot      frame terminator beat (position field ignored)
//   detect_pos          {filler, y[W_Y-1:0], x[W_X-1:0]}
//   out_valid/out_ready replay handshake
//   out_x, out_y        replayed position
//   out_eot             last replay beat of the frame
//   out_none            frame held no detections; beat carries no position
//   det_count           entries stored in the current frame
//   overflow            sticky: at least one detection dropped this frame
//   state_dbg           0 = COLLECT, 1 = DRAIN
//
// Handshake rule (both streams): a beat transfers on a cycle where valid and
// ready are both high at the rising edge. Once out_valid is raised it stays
// high, with x/y/eot/none stable, until the beat transfers.

module detect_collector #(
  parameter int IMG_WIDTH  = 45,
  parameter int IMG_HEIGHT = 45,
  parameter int MAX_DETECT = 16,
  localparam int W_X   = $clog2(IMG_WIDTH),
  localparam int W_Y   = $clog2(IMG_HEIGHT),
  localparam int W_CNT = $clog2(MAX_DETECT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             detect_pos_valid,
  output logic             detect_pos_ready,
  input  logic             detect_pos_eot,
  input  logic [31:0]      detect_pos,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W_X-1:0]   out_x,
  output logic [W_Y-1:0]   out_y,
  output logic             out_eot,
  output logic             out_none,
  output logic [W_CNT-1:0] det_count,
  output logic             overflow,
  output logic             state_dbg
);

  localparam int W_E   = W_X + W_Y;
  localparam int W_IDX = (MAX_DETECT > 1) ? $clog2(MAX_DETECT) : 1;
  localparam logic [W_CNT-1:0] MAX_CNT = W_CNT'(MAX_DETECT);

  typedef enum logic {
    COLLECT = 1'b0,
    DRAIN   = 1'b1
  } state_t;

  state_t             state, state_next;
  logic [W_E-1:0]     mem [MAX_DETECT];
  logic [W_IDX-1:0]   rd_ptr, rd_ptr_next;
  logic [W_CNT-1:0]   cnt_next;
  logic               ovf_next;
  logic               wr_en;
  logic [W_E-1:0]     pos_yx;
  logic [W_CNT-1:0]   last_idx;
  logic [W_E-1:0]     rd_entry;
  logic               is_full;
  logic               dup;

  assign pos_yx    = detect_pos[W_E-1:0];
  assign last_idx  = det_count - 1'b1;
  assign is_full   = (det_count == MAX_CNT);
  assign rd_entry  = mem[rd_ptr];
  assign state_dbg = (state == DRAIN);

`ifdef DETECT_COLLECT_DEDUP_EN
  // Only compare against a real entry; an empty frame has no "previous".
  assign dup = (det_count != '0) && (pos_yx == mem[last_idx[W_IDX-1:0]]);
`else
  assign dup = 1'b0;
`endif

  always_comb begin
    state_next       = state;
    rd_ptr_next      = rd_ptr;
    cnt_next         = det_count;
    ovf_next         = overflow;
    wr_en            = 1'b0;
    detect_pos_ready = 1'b0;
    out_valid        = 1'b0;
    out_eot          = 1'b0;
    out_none         = 1'b0;
    out_x            = '0;
    out_y            = '0;

    case (state)
      COLLECT: begin
        detect_pos_ready = 1'b1;
        if (detect_pos_valid) begin
          if (detect_pos_eot) begin
            state_next  = DRAIN;
            rd_ptr_next = '0;
          end else if (!dup) begin
            if (!is_full) begin
              wr_en    = 1'b1;
              cnt_next = det_count + 1'b1;
            end else begin
              ovf_next = 1'b1;
            end
          end
        end
      end

      DRAIN: begin
        out_valid = 1'b1;
        if (det_count == '0) begin
          // Empty frame: a single marker beat so the host still sees a frame end.
          out_none = 1'b1;
          out_eot  = 1'b1;
          if (out_ready) begin
            state_next = COLLECT;
            ovf_next   = 1'b0;
          end
        end else begin
          out_x   = rd_entry[W_X-1:0];
          out_y   = rd_entry[W_E-1:W_X];
          out_eot = (W_CNT'(rd_ptr) == last_idx);
          if (out_ready) begin
            if (out_eot) begin
              state_next  = COLLECT;
              cnt_next    = '0;
              ovf_next    = 1'b0;
              rd_ptr_next = '0;
            end else begin
              rd_ptr_next = rd_ptr + 1'b1;
            end
          end
        end
      end

      default: state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= COLLECT;
      rd_ptr    <= '0;
      det_count <= '0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_next;
      rd_ptr    <= rd_ptr_next;
      det_count <= cnt_next;
      overflow  <= ovf_next;
    end
  end

  // Storage is not reset; entries beyond det_count are never read.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem[det_count[W_IDX-1:0]] <= pos_yx;
    end
  end

endmodule

// File: tb/tb_detect_collector.sv
module tb_detect_collector;

  localparam int W_X   = 6;
  localparam int W_Y   = 6;
  localparam int W_CNT = 5;

  logic             clk;
  logic             rst;
  logic             detect_pos_valid;
  logic             detect_pos_ready;
  logic             detect_pos_eot;
  logic [31:0]      detect_pos;
  logic             out_valid;
  logic             out_ready;
  logic [W_X-1:0]   out_x;
  logic [W_Y-1:0]   out_y;
  logic             out_eot;
  logic             out_none;
  logic [W_CNT-1:0] det_count;
  logic             overflow;
  logic             state_dbg;

  detect_collector #(
    .IMG_WIDTH(45),
    .IMG_HEIGHT(45),
    .MAX_DETECT(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .detect_pos_valid(detect_pos_valid),
    .detect_pos_ready(detect_pos_ready),
    .detect_pos_eot(detect_pos_eot),
    .detect_pos(detect_pos),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_x(out_x),
    .out_y(out_y),
    .out_eot(out_eot),
    .out_none(out_none),
    .det_count(det_count),
    .overflow(overflow),
    .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [13:0] exp_q[$];   // {eot, none, y, x}
  logic [13:0] beat;
  assign beat = {out_eot, out_none, out_y, out_x};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pos(input int x, input int y);
    pos = 32'(((y & 63) << 6) | (x & 63));
  endfunction

  // ---------------- vector table ----------------
  typedef struct packed {
    logic        rst;
    logic        v;
    logic        eot;
    logic [31:0] p;
    logic        ordy;
    logic        e_rdy;
    logic        e_ov;
    logic [5:0]  e_x;
    logic [5:0]  e_y;
    logic        e_eot;
    logic        e_none;
    logic [4:0]  e_cnt;
    logic        e_ovf;
  } vec_t;

  function automatic vec_t mk(input int r, input int v, input int e, input logic [31:0] p,
                              input int ordy, input int rdy, input int ov, input int x,
                              input int y, input int eo, input int no, input int cnt,
                              input int ovf);
    vec_t t;
    t.rst = r[0]; t.v = v[0]; t.eot = e[0]; t.p = p; t.ordy = ordy[0];
    t.e_rdy = rdy[0]; t.e_ov = ov[0]; t.e_x = x[5:0]; t.e_y = y[5:0];
    t.e_eot = eo[0]; t.e_none = no[0]; t.e_cnt = cnt[4:0]; t.e_ovf = ovf[0];
    return t;
  endfunction

  vec_t vecs[19];

  // ---------------- driver tasks (entered at posedge+1) ----------------
  task automatic idle();
    rst = 1'b0; detect_pos_valid = 1'b0; detect_pos_eot = 1'b0;
    detect_pos = '0; out_ready = 1'b0;
  endtask

  task automatic send(input logic [31:0] p, input logic e);
    detect_pos_valid = 1'b1; detect_pos = p; detect_pos_eot = e;
    @(negedge clk);
    check("send_ready", detect_pos_ready, 1);
    @(posedge clk); #1;
    detect_pos_valid = 1'b0; detect_pos_eot = 1'b0; detect_pos = '0;
  endtask

  task automatic drain_n(input int n, input int stall_mode);
    logic [13:0] e;
    int stall;
    for (int k = 0; k < n; k++) begin
      if (exp_q.size() == 0) begin
        check("drain_queue_empty", 0, 1);
        return;
      end
      e = exp_q.pop_front();
      stall = (stall_mode != 0 && (k % 2) == 1) ? 2 : 0;
      out_ready = 1'b0;
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        check("stall_valid", out_valid, 1);
        check("stall_beat", beat, e);
        check("stall_in_ready", detect_pos_ready, 0);
        @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("beat_valid", out_valid, 1);
      check("beat_data", beat, e);
      check("drain_in_ready", detect_pos_ready, 0);
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  // ---------------- test ----------------
  initial begin
    int n_exp;

    vecs[0]  = mk(0,0,0,32'h0,        0, 1,0, 0, 0,0,0,0,0);
    vecs[1]  = mk(0,1,1,32'hFFFF_FFFF,0, 1,0, 0, 0,0,0,0,0);
    vecs[2]  = mk(0,0,0,32'h0,        1, 0,1, 0, 0,1,1,0,0);
    vecs[3]  = mk(0,0,0,32'h0,        0, 1,0, 0, 0,0,0,0,0);
    vecs[4]  = mk(0,1,0,pos(3,5),     0, 1,0, 0, 0,0,0,0,0);
    vecs[5]  = mk(0,1,0,pos(10,0),    0, 1,0, 0, 0,0,0,1,0);
    vecs[6]  = mk(0,1,0,pos(20,20),   0, 1,0, 0, 0,0,0,2,0);
    vecs[7]  = mk(0,1,1,32'hFFFF_FFFF,0, 1,0, 0, 0,0,0,3,0);
    vecs[8]  = mk(0,0,0,32'h0,        1, 0,1, 3, 5,0,0,3,0);
    vecs[9]  = mk(0,0,0,32'h0,        1, 0,1,10, 0,0,0,3,0);
    vecs[10] = mk(0,0,0,32'h0,        1, 0,1,20,20,1,0,3,0);
    vecs[11] = mk(0,1,0,pos(1,2),     0, 1,0, 0, 0,0,0,0,0);
    vecs[12] = mk(0,1,0,pos(4,9),     0, 1,0, 0, 0,0,0,1,0);
    vecs[13] = mk(0,1,1,32'hFFFF_FFFF,0, 1,0, 0, 0,0,0,2,0);
    vecs[14] = mk(0,0,0,32'h0,        1, 0,1, 1, 2,0,0,2,0);
    vecs[15] = mk(0,0,0,32'h0,        0, 0,1, 4, 9,1,0,2,0);
    vecs[16] = mk(0,1,0,pos(5,5),     0, 0,1, 4, 9,1,0,2,0);
    vecs[17] = mk(0,0,0,32'h0,        1, 0,1, 4, 9,1,0,2,0);
    vecs[18] = mk(0,0,0,32'h0,        0, 1,0, 0, 0,0,0,0,0);

    // Reset with a valid beat present: it must not be stored.
    idle();
    rst = 1'b1; detect_pos_valid = 1'b1; detect_pos = pos(9,9);
    repeat (2) @(posedge clk);
    #1;
    idle();

    for (int i = 0; i < 19; i++) begin
      rst = vecs[i].rst; detect_pos_valid = vecs[i].v; detect_pos_eot = vecs[i].eot;
      detect_pos = vecs[i].p; out_ready = vecs[i].ordy;
      @(negedge clk);
      check($sformatf("row%0d_ready", i), detect_pos_ready, vecs[i].e_rdy);
      check($sformatf("row%0d_valid", i), out_valid, vecs[i].e_ov);
      check($sformatf("row%0d_x", i), out_x, vecs[i].e_x);
      check($sformatf("row%0d_y", i), out_y, vecs[i].e_y);
      check($sformatf("row%0d_eot", i), out_eot, vecs[i].e_eot);
      check($sformatf("row%0d_none", i), out_none, vecs[i].e_none);
      check($sformatf("row%0d_cnt", i), det_count, vecs[i].e_cnt);
      check($sformatf("row%0d_ovf", i), overflow, vecs[i].e_ovf);
      @(posedge clk); #1;
    end
    idle();

    // Overflow: 18 detections into 16 entries, replay with stalls.
    for (int i = 0; i < 18; i++) send(pos(i, 1), 1'b0);
    send(32'hFFFF_FFFF, 1'b1);
    @(negedge clk);
    check("ovf_cnt", det_count, 16);
    check("ovf_flag", overflow, 1);
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) exp_q.push_back({(i == 15), 1'b0, 6'd1, 6'(i)});
    drain_n(16, 1);
    @(negedge clk);
    check("ovf_clear_flag", overflow, 0);
    check("ovf_clear_cnt", det_count, 0);
    check("ovf_clear_ready", detect_pos_ready, 1);
    check("ovf_clear_valid", out_valid, 0);
    @(posedge clk); #1;

    // Reset in the middle of a replay.
    for (int i = 0; i < 4; i++) begin
      send(pos(30 + i, 40 - i), 1'b0);
      exp_q.push_back({(i == 3), 1'b0, 6'(40 - i), 6'(30 + i)});
    end
    send(32'hFFFF_FFFF, 1'b1);
    drain_n(2, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_cnt", det_count, 0);
    check("rst_mid_ready", detect_pos_ready, 1);
    @(posedge clk); #1;
    exp_q.delete();
    send(pos(11, 13), 1'b0);
    send(32'hFFFF_FFFF, 1'b1);
    @(negedge clk);
    check("one_entry_cnt", det_count, 1);
    @(posedge clk); #1;
    exp_q.push_back({1'b1, 1'b0, 6'd13, 6'd11});
    drain_n(1, 0);

    // Repeated positions: collapsed only when dedup is built in.
    send(pos(7, 7), 1'b0);
    send(pos(7, 7), 1'b0);
    send(pos(8, 7), 1'b0);
    send(pos(7, 7), 1'b0);
    send(32'hFFFF_FFFF, 1'b1);
`ifdef DETECT_COLLECT_DEDUP_EN
    n_exp = 3;
    exp_q.push_back({1'b0, 1'b0, 6'd7, 6'd7});
    exp_q.push_back({1'b0, 1'b0, 6'd7, 6'd8});
    exp_q.push_back({1'b1, 1'b0, 6'd7, 6'd7});
`else
    n_exp = 4;
    exp_q.push_back({1'b0, 1'b0, 6'd7, 6'd7});
    exp_q.push_back({1'b0, 1'b0, 6'd7, 6'd7});
    exp_q.push_back({1'b0, 1'b0, 6'd7, 6'd8});
    exp_q.push_back({1'b1, 1'b0, 6'd7, 6'd7});
`endif
    @(negedge clk);
    check("dup_cnt", det_count, 32'(n_exp));
    @(posedge clk); #1;
    drain_n(n_exp, 0);
    @(negedge clk);
    check("final_valid", out_valid, 0);
    check("final_queue", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
